// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared lane constants and types for the TDM demultiplexer
package tdm_pkg;
    localparam int NUM_LANES  = 4;
    localparam int LANE_SEL_W = 2;

    typedef logic [LANE_SEL_W-1:0] lane_sel_t;

    localparam logic MODE_AUTO   = 1'b0;
    localparam logic MODE_MANUAL = 1'b1;
endpackage

// File: rtl/demux1to4.sv
// rtl/demux1to4.sv - 2-bit select plus enable to one-hot lane write-enable
module demux1to4
    import tdm_pkg::*;
(
    input  lane_sel_t              sel_i,
    input  logic                   en_i,
    output logic [NUM_LANES-1:0]   we_o
);

    always_comb begin
        we_o = '0;
        if (en_i) begin
            we_o[sel_i] = 1'b1;
        end
    end

endmodule

// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - four-lane word-serial demultiplexer with atomic frame publish
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       din,
    input  logic                   din_valid,
    input  logic                   sync,
    input  logic                   sel_mode,
    input  logic [1:0]             sel,
    output logic [4*WIDTH-1:0]     dout,
    output logic                   frame_valid,
    output logic                   frame_err
);

    logic                   mode_q;
    lane_sel_t              slot_q, slot_d;
    logic [WIDTH-1:0]       shadow_q [NUM_LANES];
    logic [4*WIDTH-1:0]     dout_q, dout_d;
    logic                   frame_valid_q, frame_err_q;
    logic                   frame_err_d;

    logic                   auto_mode;
    logic                   mode_chg;
    lane_sel_t              eff_slot;
    lane_sel_t              auto_target;
    logic [NUM_LANES-1:0]   shadow_we;
    logic [NUM_LANES-1:0]   lane_we;
    logic                   complete;

    assign auto_mode   = (sel_mode == MODE_AUTO);
    assign mode_chg    = (sel_mode != mode_q);
    // A mode change restarts the frame, so the word on that cycle sees slot 0.
    assign eff_slot    = mode_chg ? lane_sel_t'(0) : slot_q;
    assign auto_target = sync ? lane_sel_t'(0) : eff_slot;
    assign complete    = shadow_we[NUM_LANES-1];

    demux1to4 u_shadow_demux (
        .sel_i (auto_target),
        .en_i  (din_valid & auto_mode),
        .we_o  (shadow_we)
    );

    demux1to4 u_lane_demux (
        .sel_i (lane_sel_t'(sel)),
        .en_i  (din_valid & ~auto_mode),
        .we_o  (lane_we)
    );

    always_comb begin
        slot_d = slot_q;
        if (!auto_mode) begin
            slot_d = '0;
        end else if (din_valid) begin
            slot_d = lane_sel_t'(auto_target + 2'd1);
        end else if (sync || mode_chg) begin
            slot_d = '0;
        end
    end

    assign frame_err_d = auto_mode & sync & (eff_slot != 2'd0);

    // Lane 3 publishes the whole frame at once; manual writes touch one lane.
    always_comb begin
        dout_d = dout_q;
        if (complete) begin
            dout_d = {din, shadow_q[2], shadow_q[1], shadow_q[0]};
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (lane_we[i]) begin
                    dout_d[i*WIDTH +: WIDTH] = din;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_q        <= MODE_AUTO;
            slot_q        <= '0;
            dout_q        <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            mode_q        <= sel_mode;
            slot_q        <= slot_d;
            dout_q        <= dout_d;
            frame_valid_q <= complete;
            frame_err_q   <= frame_err_d;
            for (int i = 0; i < NUM_LANES; i++) begin
                if (shadow_we[i]) begin
                    shadow_q[i] <= din;
                end
            end
        end
    end

    assign dout        = dout_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// tb/tb_tdm_demux4.sv - self-checking bench for tdm_demux4 against a frame-queue model
module tb_tdm_demux4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  din;
    logic        din_valid;
    logic        sync;
    logic        sel_mode;
    logic [1:0]  sel;
    logic [31:0] dout;
    logic        frame_valid;
    logic        frame_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_lane [4];
    logic       exp_fv;
    logic       exp_fe;
    logic       prev_mode;
    logic [7:0] frame [$];

    always #5 clk = ~clk;

    tdm_demux4 #(.WIDTH(8)) dut (
        .clock       (clk),
        .reset       (rst),
        .din         (din),
        .din_valid   (din_valid),
        .sync        (sync),
        .sel_mode    (sel_mode),
        .sel         (sel),
        .dout        (dout),
        .frame_valid (frame_valid),
        .frame_err   (frame_err)
    );

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_dout();
        return {exp_lane[3], exp_lane[2], exp_lane[1], exp_lane[0]};
    endfunction

    task automatic compare_outputs();
        chk_eq("dout", dout, exp_dout());
        chk_eq("frame_valid", {31'b0, frame_valid}, {31'b0, exp_fv});
        chk_eq("frame_err", {31'b0, frame_err}, {31'b0, exp_fe});
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) exp_lane[i] = 8'h00;
        exp_fv    = 1'b0;
        exp_fe    = 1'b0;
        prev_mode = 1'b0;
        frame.delete();
    endtask

    // Frame-level view: collect words of the current frame, publish on the fourth.
    task automatic model_step(input logic v, input logic [7:0] d, input logic s,
                              input logic m, input logic [1:0] sl);
        exp_fv = 1'b0;
        exp_fe = 1'b0;
        if (m) begin
            frame.delete();
            if (v) exp_lane[sl] = d;
        end else begin
            if (m != prev_mode) begin
                frame.delete();
            end else if (s) begin
                if (frame.size() != 0) exp_fe = 1'b1;
                frame.delete();
            end
            if (v) begin
                frame.push_back(d);
                if (frame.size() == 4) begin
                    for (int i = 0; i < 4; i++) exp_lane[i] = frame[i];
                    exp_fv = 1'b1;
                    frame.delete();
                end
            end
        end
        prev_mode = m;
    endtask

    task automatic cyc(input logic v, input logic [7:0] d, input logic s,
                       input logic m, input logic [1:0] sl);
        @(negedge clk);
        compare_outputs();
        din_valid = v;
        din       = d;
        sync      = s;
        sel_mode  = m;
        sel       = sl;
        model_step(v, d, s, m, sl);
    endtask

    task automatic idle(input logic m);
        cyc(1'b0, 8'h00, 1'b0, m, 2'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        compare_outputs();
        din_valid = 1'b0;
        din       = 8'h00;
        sync      = 1'b0;
        sel_mode  = 1'b0;
        sel       = 2'd0;
        rst       = 1'b1;
        model_reset();
        #1;
        chk_eq("rst_dout", dout, 32'h0);
        chk_eq("rst_fv", {31'b0, frame_valid}, 32'h0);
        chk_eq("rst_fe", {31'b0, frame_err}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        din       = 8'h00;
        din_valid = 1'b0;
        sync      = 1'b0;
        sel_mode  = 1'b0;
        sel       = 2'd0;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // basic frame with sync on first word
        cyc(1'b1, 8'h11, 1'b1, 1'b0, 2'd0);
        cyc(1'b1, 8'h22, 1'b0, 1'b0, 2'd0);
        cyc(1'b1, 8'h33, 1'b0, 1'b0, 2'd0);
        cyc(1'b1, 8'h44, 1'b0, 1'b0, 2'd0);
        idle(1'b0);
        chk_eq("frame1", dout, 32'h44332211);

        // back-to-back frames
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0, 2'd0);
        idle(1'b0);
        chk_eq("frameB", dout, 32'hB3B2B1B0);

        // partial frame abandoned by sync
        cyc(1'b1, 8'h01, 1'b0, 1'b0, 2'd0);
        cyc(1'b1, 8'h02, 1'b0, 1'b0, 2'd0);
        cyc(1'b1, 8'h10, 1'b1, 1'b0, 2'd0);
        cyc(1'b1, 8'h20, 1'b0, 1'b0, 2'd0);
        cyc(1'b1, 8'h30, 1'b0, 1'b0, 2'd0);
        cyc(1'b1, 8'h40, 1'b0, 1'b0, 2'd0);
        idle(1'b0);
        chk_eq("resync", dout, 32'h40302010);

        // manual mode after reset, sync ignored
        do_reset();
        cyc(1'b1, 8'h5A, 1'b1, 1'b1, 2'd2);
        cyc(1'b0, 8'h00, 1'b1, 1'b1, 2'd1);
        cyc(1'b1, 8'hC3, 1'b0, 1'b1, 2'd0);
        cyc(1'b0, 8'h00, 1'b1, 1'b1, 2'd0);
        idle(1'b1);
        chk_eq("manual", dout, 32'h005A00C3);

        // mode round trip drops the partial frame silently
        do_reset();
        cyc(1'b1, 8'hE1, 1'b0, 1'b0, 2'd0);
        cyc(1'b1, 8'hE2, 1'b0, 1'b0, 2'd0);
        idle(1'b1);
        idle(1'b0);
        for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, 2'd0);
        idle(1'b0);
        chk_eq("mode_rt", dout, 32'h04030201);

        // reset in the middle of a frame
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0, 2'd0);
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'h90 + 8'(i), 1'b0, 1'b0, 2'd0);
        idle(1'b0);
        chk_eq("post_rst", dout, 32'h93929190);

        // randomized traffic
        begin
            logic m;
            m = 1'b0;
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(0, 49) == 0) m = ~m;
                cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 15) == 0,
                    m, 2'($urandom_range(0, 3)));
            end
        end
        @(negedge clk);
        compare_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
